// File: rtl/fetch_pc_unit.sv
// Fetch PC sequencer: drives instruction-memory requests and applies branch/jump redirects.
// Optional `PC_ALIGN_CHECK_EN rejects word-misaligned redirect targets and raises a sticky misalign_err.
module fetch_pc_unit #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              enable,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic [DATA_W-1:0] branch_pc,
  input  logic [DATA_W-1:0] jump_pc,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] updated_pc,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_pc,
  output logic              flush,
  output logic              misalign_err
);

  typedef enum logic [1:0] {BOOT, REQ, HOLD} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] pc_d, pend_pc_q, pend_pc_d, fetch_pc_d, target;
  logic              pend_q, pend_d, fv_d, flush_d, err_q, err_d;
  logic              redir, misaligned, redir_ok;

  assign redir  = jump | branch_taken;
  assign target = jump ? jump_pc : branch_pc;

`ifdef PC_ALIGN_CHECK_EN
  assign misaligned = redir & (|target[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  assign redir_ok     = redir & ~misaligned;
  assign imem_req     = (state_q == REQ);
  assign imem_addr    = pc;
  assign updated_pc   = pc + DATA_W'(4);
  assign misalign_err = err_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    fetch_pc_d = fetch_pc;
    fv_d       = 1'b0;
    flush_d    = 1'b0;
    err_d      = err_q | misaligned;
    case (state_q)
      REQ: begin
        if (imem_ack) begin
          pend_d  = 1'b0;
          state_d = enable ? REQ : HOLD;
          // A redirect seen this cycle beats an older pending one.
          if (redir_ok) begin
            pc_d    = target;
            flush_d = 1'b1;
          end else if (pend_q) begin
            pc_d    = pend_pc_q;
            flush_d = 1'b1;
          end else begin
            pc_d       = pc + DATA_W'(4);
            fv_d       = 1'b1;
            fetch_pc_d = pc;
          end
        end else if (redir_ok) begin
          // Address must stay stable until ack, so park the target.
          pend_d    = 1'b1;
          pend_pc_d = target;
        end
      end
      default: begin
        state_d = enable ? REQ : HOLD;
        if (redir_ok) begin
          pc_d    = target;
          flush_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q     <= BOOT;
      pc          <= RESET_PC;
      pend_q      <= 1'b0;
      pend_pc_q   <= RESET_PC;
      fetch_pc    <= RESET_PC;
      fetch_valid <= 1'b0;
      flush       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc          <= pc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      fetch_pc    <= fetch_pc_d;
      fetch_valid <= fv_d;
      flush       <= flush_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table, misalign sequence, then random traffic vs. a transaction model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        arst_n, enable, branch_taken, jump, imem_ack;
  logic [31:0] branch_pc, jump_pc;
  logic        imem_req, fetch_valid, flush, misalign_err;
  logic [31:0] imem_addr, pc, updated_pc, fetch_pc;

  int checks = 0;
  int errors = 0;

  fetch_pc_unit #(.DATA_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .branch_taken(branch_taken), .jump(jump),
    .branch_pc(branch_pc), .jump_pc(jump_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .pc(pc), .updated_pc(updated_pc), .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc), .flush(flush), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst_n, en, br, jp, ack;
    logic [31:0] bpc, jpc;
    bit req;
    logic [31:0] pc;
    bit fv;
    logic [31:0] fpc;
    bit fl;
  } vec_t;

  vec_t tbl[$];

  // Reference: "where is fetch" as a phase, a program counter and an optional parked target.
  bit          align_chk;
  int          m_phase;  // 0 = just reset, 1 = requesting, 2 = idle
  logic [31:0] m_pc, m_fpc, m_park;
  bit          m_parked, m_fv, m_fl, m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model(input bit rst_n, en, br, jp, ack, input logic [31:0] bpc, jpc);
    logic [31:0] tgt;
    bit          want, bad;
    m_fv = 0;
    m_fl = 0;
    if (!rst_n) begin
      m_phase = 0; m_pc = 0; m_fpc = 0; m_parked = 0; m_err = 0;
      return;
    end
    tgt  = jp ? jpc : bpc;
    want = jp || br;
    bad  = align_chk && want && (tgt % 4 != 0);
    if (bad) m_err = 1;
    want = want && !bad;
    if (m_phase == 1 && !ack) begin
      if (want) begin m_parked = 1; m_park = tgt; end
      return;
    end
    if (m_phase == 1) begin
      if (want)          begin m_pc = tgt;    m_fl = 1; end
      else if (m_parked) begin m_pc = m_park; m_fl = 1; end
      else begin m_fpc = m_pc; m_fv = 1; m_pc = m_pc + 4; end
      m_parked = 0;
    end else if (want) begin
      m_pc = tgt; m_fl = 1;
    end
    m_phase = en ? 1 : 2;
  endtask

  task automatic step(input bit rst_n, en, br, jp, ack, input logic [31:0] bpc, jpc);
    arst_n = rst_n; enable = en; branch_taken = br; jump = jp; imem_ack = ack;
    branch_pc = bpc; jump_pc = jpc;
    @(posedge clk);
    model(rst_n, en, br, jp, ack, bpc, jpc);
    #1;
  endtask

  task automatic add(input bit rst_n, en, br, jp, ack, input logic [31:0] bpc, jpc,
                     input bit req, input logic [31:0] epc, input bit fv, input logic [31:0] fpc, input bit fl);
    vec_t v;
    v.rst_n = rst_n; v.en = en; v.br = br; v.jp = jp; v.ack = ack; v.bpc = bpc; v.jpc = jpc;
    v.req = req; v.pc = epc; v.fv = fv; v.fpc = fpc; v.fl = fl;
    tbl.push_back(v);
  endtask

  task automatic cmp_model();
    chk("rnd_imem_req", 32'(imem_req), 32'(m_phase == 1));
    chk("rnd_pc", pc, m_pc);
    chk("rnd_imem_addr", imem_addr, m_pc);
    chk("rnd_updated_pc", updated_pc, m_pc + 32'd4);
    chk("rnd_fetch_valid", 32'(fetch_valid), 32'(m_fv));
    chk("rnd_fetch_pc", fetch_pc, m_fpc);
    chk("rnd_flush", 32'(flush), 32'(m_fl));
    chk("rnd_misalign_err", 32'(misalign_err), 32'(m_err));
    chk("rnd_fv_flush_exclusive", 32'(fetch_valid & flush), 32'd0);
  endtask

  initial begin
`ifdef PC_ALIGN_CHECK_EN
    align_chk = 1;
`else
    align_chk = 0;
`endif
    m_phase = 0; m_pc = 0; m_fpc = 0; m_park = 0; m_parked = 0; m_fv = 0; m_fl = 0; m_err = 0;
    arst_n = 0; enable = 0; branch_taken = 0; jump = 0; imem_ack = 0; branch_pc = 0; jump_pc = 0;

    //   rst en br jp ack  bpc           jpc            req pc            fv fpc           fl
    add(0, 1, 0, 0, 1, 32'h0,     32'h0,          0, 32'h0,         0, 32'h0,         0); // reset
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h0,         0, 32'h0,         0); // BOOT, ack ignored
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h4,         1, 32'h0,         0);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h8,         1, 32'h4,         0);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'hC,         1, 32'h8,         0);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h10,        1, 32'hC,         0);
    add(1, 1, 0, 0, 0, 32'h0,     32'h0,          1, 32'h10,        0, 32'hC,         0); // ack withheld x3
    add(1, 1, 0, 0, 0, 32'h0,     32'h0,          1, 32'h10,        0, 32'hC,         0);
    add(1, 1, 0, 0, 0, 32'h0,     32'h0,          1, 32'h10,        0, 32'hC,         0);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h14,        1, 32'h10,        0);
    add(1, 1, 0, 1, 1, 32'h0,     32'h20,         1, 32'h20,        0, 32'h10,        1); // jump to 0x20
    add(1, 1, 1, 0, 0, 32'h80,    32'h0,          1, 32'h20,        0, 32'h10,        0); // branch parked
    add(1, 1, 0, 0, 0, 32'h0,     32'h0,          1, 32'h20,        0, 32'h10,        0);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h80,        0, 32'h10,        1); // parked applied
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h84,        1, 32'h80,        0);
    add(1, 1, 1, 1, 1, 32'h100,   32'h4000,       1, 32'h4000,      0, 32'h80,        1); // jump wins
    add(1, 0, 0, 0, 1, 32'h0,     32'h0,          0, 32'h4004,      1, 32'h4000,      0); // to HOLD
    add(1, 0, 0, 0, 0, 32'h0,     32'h0,          0, 32'h4004,      0, 32'h4000,      0);
    add(1, 1, 0, 0, 0, 32'h0,     32'h0,          1, 32'h4004,      0, 32'h4000,      0);
    add(1, 1, 0, 1, 1, 32'h0,     32'hFFFF_FFFC,  1, 32'hFFFF_FFFC, 0, 32'h4000,      1);
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h0,         1, 32'hFFFF_FFFC, 0); // wrap
    add(0, 1, 0, 0, 1, 32'h0,     32'h0,          0, 32'h0,         0, 32'h0,         0); // mid-transfer reset
    add(1, 1, 0, 0, 1, 32'h0,     32'h0,          1, 32'h0,         0, 32'h0,         0); // late ack ignored

    foreach (tbl[i]) begin
      step(tbl[i].rst_n, tbl[i].en, tbl[i].br, tbl[i].jp, tbl[i].ack, tbl[i].bpc, tbl[i].jpc);
      chk($sformatf("v%0d_imem_req", i), 32'(imem_req), 32'(tbl[i].req));
      chk($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      chk($sformatf("v%0d_imem_addr", i), imem_addr, tbl[i].pc);
      chk($sformatf("v%0d_updated_pc", i), updated_pc, tbl[i].pc + 32'd4);
      chk($sformatf("v%0d_fetch_valid", i), 32'(fetch_valid), 32'(tbl[i].fv));
      chk($sformatf("v%0d_fetch_pc", i), fetch_pc, tbl[i].fpc);
      chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].fl));
      chk($sformatf("v%0d_misalign_err", i), 32'(misalign_err), 32'd0);
    end

    // Misaligned branch target while idle after reset, then sticky until reset.
    step(0, 0, 0, 0, 0, 32'h0, 32'h0);
    step(1, 0, 1, 0, 0, 32'h82, 32'h0);
    chk("mis_pc", pc, align_chk ? 32'h0 : 32'h82);
    chk("mis_flush", 32'(flush), align_chk ? 32'd0 : 32'd1);
    chk("mis_err", 32'(misalign_err), align_chk ? 32'd1 : 32'd0);
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 1, 32'h0, 32'h0);
    chk("mis_err_sticky", 32'(misalign_err), align_chk ? 32'd1 : 32'd0);
    step(0, 1, 0, 0, 0, 32'h0, 32'h0);
    chk("mis_err_reset", 32'(misalign_err), 32'd0);
    chk("mis_pc_reset", pc, 32'h0);

    // Randomized traffic, including pending overwrite and misaligned targets.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] b, j;
      b = $urandom() & 32'hFFFF_FFFC;
      j = $urandom() & 32'hFFFF_FFFC;
      if ($urandom_range(7) == 0) b[1:0] = 2'($urandom_range(3));
      if ($urandom_range(7) == 0) j[1:0] = 2'($urandom_range(3));
      step($urandom_range(59) != 0, $urandom_range(4) != 0, $urandom_range(6) == 0,
           $urandom_range(9) == 0, $urandom_range(4) < 3, b, j);
      cmp_model();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of PC, addresses and redirect targets.
REQ-002 Parameter RESET_PC, default 0: PC loaded by reset.
REQ-003 clk  input  1: sole clock; all state updates on rising edge.
REQ-004 arst_n  input  1: reset, synchronous, active-low.
REQ-005 enable  input  1: high = fetch may advance; low = stall.
REQ-006 branch_taken  input  1: redirect request to branch_pc.
REQ-007 jump  input  1: redirect request to jump_pc.
REQ-008 branch_pc  input  DATA_W: branch target from branch unit.
REQ-009 jump_pc  input  DATA_W: jump target from branch unit.
REQ-010 imem_req  output  1: instruction-memory request.
REQ-011 imem_addr  output  DATA_W: request address; equals pc.
REQ-012 imem_ack  input  1: memory accepts and completes the request this cycle.
REQ-013 pc  output  DATA_W: current fetch PC (registered).
REQ-014 updated_pc  output  DATA_W: pc+4, fed back to branch unit.
REQ-015 fetch_valid  output  1: registered one-cycle pulse, the instruction just fetched at fetch_pc is usable.
REQ-016 fetch_pc  output  DATA_W: registered address of the last completed, non-discarded fetch.
REQ-017 flush  output  1: registered one-cycle pulse, a redirect was applied.
REQ-018 misalign_err  output  1: sticky misaligned-target flag (see Configuration).

Function
REQ-019 FSM states BOOT, REQ, HOLD; reset enters BOOT.
REQ-020 BOOT: imem_req=0 for exactly one cycle, then REQ if enable=1, else HOLD.
REQ-021 REQ: imem_req=1; imem_addr SHALL stay stable until imem_ack=1.
REQ-022 REQ with imem_ack=1 and no redirect (current or pending): next cycle pc=pc+4, fetch_valid=1, fetch_pc=old pc; stay in REQ if enable=1, else HOLD.
REQ-023 HOLD: imem_req=0; go to REQ on the cycle after enable=1 is sampled.
REQ-024 Redirect target selection: jump=1 selects jump_pc; else branch_taken=1 selects branch_pc; jump wins when both asserted.
REQ-025 Redirect in REQ without ack: target latched into pending register; request held unchanged; pending overwritten by any later redirect before ack.
REQ-026 Ack with redirect (same-cycle or pending): fetched instruction discarded (fetch_valid=0); next cycle pc=target (same-cycle redirect has priority over pending), flush=1, pending cleared.
REQ-027 Redirect in BOOT or HOLD: next cycle pc=target, flush=1; state transitions unaffected.
REQ-028 Arithmetic: pc+4 and updated_pc wrap modulo 2^DATA_W; no overflow flag.
REQ-029 At most one fetch_valid and one flush per cycle; never both in the same cycle.

Reset
REQ-030 arst_n=0 sampled on an edge: pc=RESET_PC, updated_pc=RESET_PC+4, fetch_pc=RESET_PC, imem_req=0, fetch_valid=0, flush=0, misalign_err=0, pending cleared, state=BOOT.
REQ-031 Reset mid-transfer abandons the outstanding request; a late imem_ack during BOOT is ignored.

Configuration
REQ-032 Macro PC_ALIGN_CHECK_EN defined: a selected redirect target with bits[1:0]!=0 is not applied (pc unchanged, no flush, not latched as pending), and misalign_err sets and holds until reset.
REQ-033 PC_ALIGN_CHECK_EN undefined: all targets applied unchanged; misalign_err tied 0; port retained.

Verification
REQ-034 Reset release, enable=1, imem_ack always 1 -> imem_req rises after 1 BOOT cycle; fetch_pc sequence 0x0,0x4,0x8 with fetch_valid each cycle.
REQ-035 REQ at pc=0x10, ack withheld 3 cycles -> imem_addr stays 0x10; single fetch_valid with fetch_pc=0x10 after ack.
REQ-036 pc=0x20, branch_taken=1, branch_pc=0x80, ack two cycles later -> no fetch_valid for 0x20; flush=1; pc=0x80; next request addr 0x80.
REQ-037 jump=1 (jump_pc=0x4000) and branch_taken=1 (branch_pc=0x100) with ack same cycle -> pc=0x4000, flush=1, fetch_valid=0.
REQ-038 pc=0xFFFFFFFC, ack -> pc wraps to 0x0, updated_pc=0x4.
REQ-039 PC_ALIGN_CHECK_EN defined, branch_pc=0x82 -> pc unchanged, flush=0, misalign_err=1 until arst_n=0.
